// File: rtl/pll_reset_sequencer.sv
// PLL bring-up supervisor: holds the PLL in reset, waits for a stable lock, then
// releases the per-domain resets one by one; lock loss or repeated timeouts re-sequence or fault.
`timescale 1ns/1ps
module pll_reset_sequencer #(
   parameter int NUM_DOMAINS   = 8,
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int SEQ_GAP       = 8,
   parameter int MAX_RETRIES   = 3,
   parameter int CNT_W         = 16
) (
   input  logic                   refclk,
   input  logic                   rst_n,
   input  logic                   pll_locked_async,
   input  logic                   restart,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] domain_rst_n,
   output logic                   all_ready,
   output logic                   fault,
   output logic [2:0]             state,
   output logic [7:0]             loss_count
);

   localparam logic [2:0] S_PLL_RST = 3'd0;
   localparam logic [2:0] S_WAIT    = 3'd1;
   localparam logic [2:0] S_STABLE  = 3'd2;
   localparam logic [2:0] S_RELEASE = 3'd3;
   localparam logic [2:0] S_RUN     = 3'd4;
   localparam logic [2:0] S_FAULT   = 3'd5;

   localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
   localparam int RTY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(SEQ_GAP - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);
   localparam logic [RTY_W-1:0] RTY_ONE  = RTY_W'(1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [1:0]             sync_q, sync_d;
   logic [2:0]             state_q, state_d;
   logic [CNT_W-1:0]       timer_q, timer_d;
   logic [RTY_W-1:0]       retry_q, retry_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [7:0]             loss_q, loss_d;
   logic                   pll_rst_q, pll_rst_d;
   logic [NUM_DOMAINS-1:0] dom_q, dom_d;
   logic                   ready_q, ready_d;
   logic                   fault_q, fault_d;
   logic                   locked_s;

   assign locked_s = sync_q[1];

   always_comb begin
      sync_d    = {sync_q[0], pll_locked_async};
      state_d   = state_q;
      timer_d   = timer_q;
      retry_d   = retry_q;
      idx_d     = idx_q;
      loss_d    = loss_q;
      pll_rst_d = pll_rst_q;
      dom_d     = dom_q;
      ready_d   = ready_q;
      fault_d   = fault_q;

      case (state_q)
         S_PLL_RST: begin
            pll_rst_d = 1'b1;
            if (timer_q == RST_LAST) begin
               state_d   = S_WAIT;
               pll_rst_d = 1'b0;
               timer_d   = '0;
            end else begin
               timer_d = timer_q + CNT_ONE;
            end
         end
         S_WAIT: begin
            if (locked_s) begin
               state_d = S_STABLE;
               timer_d = '0;
            end else if (timer_q == TO_LAST) begin
               timer_d   = '0;
               retry_d   = retry_q + RTY_ONE;
               pll_rst_d = 1'b1;
               if (retry_d == RTY_MAX) begin
                  state_d = S_FAULT;
                  fault_d = 1'b1;
               end else begin
                  state_d = S_PLL_RST;
               end
            end else begin
               timer_d = timer_q + CNT_ONE;
            end
         end
         S_STABLE: begin
            // A dropout here is treated as a glitch: the window restarts, nothing is counted.
            if (!locked_s) begin
               state_d = S_WAIT;
               timer_d = '0;
            end else if (timer_q == STB_LAST) begin
               timer_d  = '0;
               retry_d  = '0;
               dom_d[0] = 1'b1;
               idx_d    = IDX_ONE;
               if (NUM_DOMAINS == 1) begin
                  state_d = S_RUN;
                  ready_d = 1'b1;
               end else begin
                  state_d = S_RELEASE;
               end
            end else begin
               timer_d = timer_q + CNT_ONE;
            end
         end
         S_RELEASE: begin
            if (timer_q == GAP_LAST) begin
               timer_d      = '0;
               dom_d[idx_q] = 1'b1;
               idx_d        = idx_q + IDX_ONE;
               if (idx_q == LAST_IDX) begin
                  state_d = S_RUN;
                  ready_d = 1'b1;
               end
            end else begin
               timer_d = timer_q + CNT_ONE;
            end
         end
         S_RUN: begin
         end
         S_FAULT: begin
            pll_rst_d = 1'b1;
            dom_d     = '0;
            fault_d   = 1'b1;
            if (restart) begin
               state_d = S_PLL_RST;
               timer_d = '0;
               retry_d = '0;
               fault_d = 1'b0;
            end
         end
         default: begin
            state_d   = S_PLL_RST;
            timer_d   = '0;
            pll_rst_d = 1'b1;
            dom_d     = '0;
            ready_d   = 1'b0;
            fault_d   = 1'b0;
         end
      endcase

      // Lock loss once any domain may be live overrides whatever the state logic chose.
      if ((state_q == S_RELEASE || state_q == S_RUN) && !locked_s) begin
         state_d   = S_PLL_RST;
         timer_d   = '0;
         pll_rst_d = 1'b1;
         dom_d     = '0;
         ready_d   = 1'b0;
         loss_d    = sat_inc8(loss_q);
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         state_q   <= S_PLL_RST;
         timer_q   <= '0;
         retry_q   <= '0;
         idx_q     <= '0;
         loss_q    <= '0;
         pll_rst_q <= 1'b1;
         dom_q     <= '0;
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         state_q   <= state_d;
         timer_q   <= timer_d;
         retry_q   <= retry_d;
         idx_q     <= idx_d;
         loss_q    <= loss_d;
         pll_rst_q <= pll_rst_d;
         dom_q     <= dom_d;
         ready_q   <= ready_d;
         fault_q   <= fault_d;
      end
   end

   assign pll_rst      = pll_rst_q;
   assign domain_rst_n = dom_q;
   assign all_ready    = ready_q;
   assign fault        = fault_q;
   assign state        = state_q;
   assign loss_count   = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters; outputs are
// sampled on the falling edge, so "sample k" is the value after k rising edges.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

   localparam int ND    = 4;
   localparam int LIMIT = 300;

   logic          refclk = 1'b0;
   logic          rst_n;
   logic          pll_locked_async;
   logic          restart;
   logic          pll_rst;
   logic [ND-1:0] domain_rst_n;
   logic          all_ready;
   logic          fault;
   logic [2:0]    state;
   logic [7:0]    loss_count;

   int vectors     = 0;
   int miscompares = 0;

   always #10 refclk = ~refclk;

   pll_reset_sequencer #(
      .NUM_DOMAINS(ND), .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8),
      .SEQ_GAP(2), .MAX_RETRIES(2), .CNT_W(16)
   ) dut (
      .refclk(refclk), .rst_n(rst_n), .pll_locked_async(pll_locked_async),
      .restart(restart), .pll_rst(pll_rst), .domain_rst_n(domain_rst_n),
      .all_ready(all_ready), .fault(fault), .state(state), .loss_count(loss_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (all_ready !== 1'b1 && n < LIMIT) begin step(1); n++; end
      if (all_ready !== 1'b1) n = -1;
   endtask

   task automatic wait_dom_bit(input int b, output int n);
      n = 0;
      while (domain_rst_n[b] !== 1'b1 && n < LIMIT) begin step(1); n++; end
      if (domain_rst_n[b] !== 1'b1) n = -1;
   endtask

   task automatic wait_dom(input logic [ND-1:0] v, output int n);
      n = 0;
      while (domain_rst_n !== v && n < LIMIT) begin step(1); n++; end
      if (domain_rst_n !== v) n = -1;
   endtask

   task automatic wait_state(input logic [2:0] s, output int n);
      n = 0;
      while (state !== s && n < LIMIT) begin step(1); n++; end
      if (state !== s) n = -1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            n;
      int            hi;
      logic [47:0]   hist;
      logic [ND-1:0] dom_seen;
      logic [2:0]    st47;
      logic          f47;

      rst_n = 1'b0; pll_locked_async = 1'b0; restart = 1'b0;
      step(3);
      check("rst_pll_rst", 64'(pll_rst), 64'(1));
      check("rst_dom", 64'(domain_rst_n), 64'(0));
      check("rst_ready", 64'(all_ready), 64'(0));
      check("rst_fault", 64'(fault), 64'(0));
      check("rst_state", 64'(state), 64'(0));
      check("rst_loss", 64'(loss_count), 64'(0));

      // Nominal bring-up: lock arrives 3 cycles after pll_rst falls.
      rst_n = 1'b1;
      hi = 0;
      while (pll_rst === 1'b1 && hi < LIMIT) begin hi++; step(1); end
      check("nom_pll_rst_len", 64'(hi), 64'(4));
      check("nom_wait_state", 64'(state), 64'(1));
      step(3);
      pll_locked_async = 1'b1;
      wait_dom_bit(0, n);
      check("nom_bit0_delay", 64'(n), 64'(11));
      check("nom_bit0_dom", 64'(domain_rst_n), 64'(4'b0001));
      check("nom_release_state", 64'(state), 64'(3));
      wait_dom_bit(1, n);
      check("nom_bit1_gap", 64'(n), 64'(2));
      check("nom_bit1_dom", 64'(domain_rst_n), 64'(4'b0011));
      wait_dom_bit(2, n);
      check("nom_bit2_gap", 64'(n), 64'(2));
      check("nom_ready_early", 64'(all_ready), 64'(0));
      wait_dom_bit(3, n);
      check("nom_bit3_gap", 64'(n), 64'(2));
      check("nom_ready", 64'(all_ready), 64'(1));
      check("nom_run_state", 64'(state), 64'(4));
      check("nom_loss", 64'(loss_count), 64'(0));

      restart = 1'b1; step(1); restart = 1'b0;
      check("run_restart_ignored", 64'(state), 64'(4));

      // Loss of lock in RUN for 5 cycles.
      pll_locked_async = 1'b0;
      step(2);
      check("loss_sync_delay", 64'(state), 64'(4));
      step(1);
      check("loss_dom", 64'(domain_rst_n), 64'(0));
      check("loss_ready", 64'(all_ready), 64'(0));
      check("loss_count1", 64'(loss_count), 64'(1));
      check("loss_pll_rst", 64'(pll_rst), 64'(1));
      check("loss_state", 64'(state), 64'(0));
      step(2);
      pll_locked_async = 1'b1;
      wait_ready(n);
      check("loss_rerun", 64'(n), 64'(17));
      check("loss_rerun_dom", 64'(domain_rst_n), 64'(4'b1111));

      // Asynchronous reset while bits 0 and 1 are released.
      pll_locked_async = 1'b0;
      step(5);
      pll_locked_async = 1'b1;
      wait_dom(4'b0011, n);
      check("mid_partial", 64'(n), 64'(13));
      check("mid_loss2", 64'(loss_count), 64'(2));
      #3 rst_n = 1'b0;
      #1;
      check("async_dom", 64'(domain_rst_n), 64'(0));
      check("async_pll_rst", 64'(pll_rst), 64'(1));
      check("async_state", 64'(state), 64'(0));
      check("async_loss", 64'(loss_count), 64'(0));
      check("async_ready", 64'(all_ready), 64'(0));

      // No lock ever: two 4-cycle pll_rst pulses, FAULT after 48 edges.
      pll_locked_async = 1'b0;
      step(2);
      rst_n = 1'b1;
      hist = '0; dom_seen = '0; st47 = '0; f47 = 1'b0;
      for (int i = 0; i < 48; i++) begin
         hist[i]  = pll_rst;
         dom_seen = dom_seen | domain_rst_n;
         if (i == 47) begin st47 = state; f47 = fault; end
         step(1);
      end
      check("nolock_pll_rst_wave", 64'(hist), 64'(48'h0000_0F00_000F));
      check("nolock_dom", 64'(dom_seen), 64'(0));
      check("nolock_state47", 64'(st47), 64'(1));
      check("nolock_fault47", 64'(f47), 64'(0));
      check("nolock_fault48", 64'(fault), 64'(1));
      check("nolock_state48", 64'(state), 64'(5));
      check("nolock_pll_rst48", 64'(pll_rst), 64'(1));
      pll_locked_async = 1'b1;
      step(4);
      check("fault_ignores_lock", 64'(state), 64'(5));
      check("fault_dom", 64'(domain_rst_n), 64'(0));

      // Restart from FAULT with lock present.
      restart = 1'b1; step(1); restart = 1'b0;
      check("restart_fault", 64'(fault), 64'(0));
      check("restart_state", 64'(state), 64'(0));
      hi = 0;
      while (pll_rst === 1'b1 && hi < LIMIT) begin hi++; step(1); end
      check("restart_pll_rst_len", 64'(hi), 64'(4));
      wait_ready(n);
      check("restart_release", 64'(n), 64'(15));
      check("restart_dom", 64'(domain_rst_n), 64'(4'b1111));
      check("restart_loss", 64'(loss_count), 64'(0));

      // Glitch in STABLE: reset with lock held high, drop it at stable-count 5.
      rst_n = 1'b0; step(2); rst_n = 1'b1;
      wait_state(3'd2, n);
      check("glitch_stable_entry", 64'(n), 64'(5));
      step(5);
      pll_locked_async = 1'b0;
      step(3);
      check("glitch_back_wait", 64'(state), 64'(1));
      check("glitch_no_release", 64'(domain_rst_n), 64'(0));
      pll_locked_async = 1'b1;
      step(2);
      check("glitch_still_wait", 64'(state), 64'(1));
      step(1);
      check("glitch_restable", 64'(state), 64'(2));
      step(7);
      check("glitch_window_state", 64'(state), 64'(2));
      check("glitch_window_dom", 64'(domain_rst_n), 64'(0));
      step(1);
      check("glitch_bit0", 64'(domain_rst_n), 64'(4'b0001));
      check("glitch_release", 64'(state), 64'(3));
      check("glitch_loss", 64'(loss_count), 64'(0));
      wait_ready(n);
      check("glitch_ready", 64'(n), 64'(6));

      // Saturation of loss_count.
      for (int k = 0; k < 255; k++) begin
         pll_locked_async = 1'b0;
         step(5);
         pll_locked_async = 1'b1;
         wait_ready(n);
         check("sat_rerun", 64'(n), 64'(17));
      end
      check("sat_255", 64'(loss_count), 64'(255));
      pll_locked_async = 1'b0;
      step(3);
      check("sat_hold", 64'(loss_count), 64'(255));
      check("sat_loss_state", 64'(state), 64'(0));
      wait_state(3'd5, n);
      check("sat_fault_delay", 64'(n), 64'(48));
      pll_locked_async = 1'b1;
      step(3);
      restart = 1'b1; step(1); restart = 1'b0;
      wait_ready(n);
      check("sat_restart_ready", 64'(n), 64'(19));
      check("sat_restart_loss", 64'(loss_count), 64'(255));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
